// File: rtl/powlib_ipcopy.sv
// powlib_ipcopy: bus-master copy engine. Issues read requests to a source range,
// buffers the returned words in order, and writes them back to a destination range.

`ifndef POWLIB_BW
`define POWLIB_BW 8
`endif
`ifndef POWLIB_OPW
`define POWLIB_OPW 4
`endif
`ifndef POWLIB_OP_WRITE
`define POWLIB_OP_WRITE 4'd0
`endif
`ifndef POWLIB_OP_READ
`define POWLIB_OP_READ 4'd1
`endif

module powlib_ipcopy #(
  parameter int unsigned B_BPD    = 2,
  parameter int unsigned B_AW     = `POWLIB_BW*B_BPD,
  parameter int unsigned B_WW     = `POWLIB_BW*B_BPD + B_BPD + `POWLIB_OPW,
  parameter logic [B_AW-1:0] RET_ADDR = 'hFFF0,
  parameter int unsigned MAXOUT   = 4,
  parameter int unsigned LENW     = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [B_AW-1:0] src,
  input  logic [B_AW-1:0] dst,
  input  logic [LENW-1:0] len,
  output logic            busy,
  output logic            done,
  output logic [B_AW-1:0] wraddr,
  output logic [B_WW-1:0] wrdata,
  output logic            wrvld,
  input  logic            wrrdy,
  input  logic [B_AW-1:0] rdaddr,
  input  logic [B_WW-1:0] rddata,
  input  logic            rdvld,
  output logic            rdrdy
);

  localparam int unsigned B_DW  = `POWLIB_BW*B_BPD;
  localparam int unsigned B_BEW = B_BPD;
  localparam int unsigned PW    = (MAXOUT > 1) ? $clog2(MAXOUT) : 1;
  localparam logic [PW:0]      OUT_MAX = (PW+1)'(MAXOUT);
  localparam logic [B_AW-1:0]  STEP    = B_AW'(B_BPD);

  typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

  state_e          state_q, state_d;
  logic [B_AW-1:0] src_q, src_d, dst_q, dst_d;
  logic [LENW-1:0] rcnt_q, rcnt_d, wcnt_q, wcnt_d;
  logic [PW:0]     out_q, out_d;

  // Response FIFO; occupancy never exceeds the outstanding-read count.
  logic [B_DW-1:0] fifo_mem [MAXOUT];
  logic [PW-1:0]   rptr_q, wptr_q;
  logic [PW:0]     fcnt_q;

  // Request output register.
  logic [B_AW-1:0] wraddr_q, wraddr_d;
  logic [B_WW-1:0] wrdata_q, wrdata_d;
  logic            wrvld_q, wrvld_d;
  logic            is_wr_q, is_wr_d;

  logic push, pop, accept, load_ok, fifo_empty, issue_wr, issue_rd;
  logic unused_rd_bits;

  assign unused_rd_bits = ^rddata[B_WW-1:B_DW];

  assign rdrdy  = 1'b1;
  assign busy   = (state_q == StActive);
  assign done   = (state_q == StDone);
  assign wraddr = wraddr_q;
  assign wrdata = wrdata_q;
  assign wrvld  = wrvld_q;

  // Handshake and packet-selection qualifiers.
  always_comb begin
    fifo_empty = (fcnt_q == '0);
    accept     = wrvld_q && wrrdy;
    load_ok    = !wrvld_q || wrrdy;
    push       = rdvld && (state_q == StActive) && (rdaddr == RET_ADDR);
    issue_wr   = (state_q == StActive) && load_ok && !fifo_empty;
    issue_rd   = (state_q == StActive) && load_ok && fifo_empty &&
                 (rcnt_q != '0) && (out_q < OUT_MAX);
    pop        = issue_wr;
  end

  // Next-state, counters and address bookkeeping (applied when a packet is issued).
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rcnt_d  = rcnt_q;
    wcnt_d  = wcnt_q;
    out_d   = out_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_d   = src;
          dst_d   = dst;
          rcnt_d  = len;
          wcnt_d  = len;
          out_d   = '0;
          state_d = (len != '0) ? StActive : StDone;
        end
      end
      StActive: begin
        if (accept && is_wr_q) begin
          wcnt_d = wcnt_q - 1'b1;
          if (wcnt_q == LENW'(1)) state_d = StDone;
        end
        if (issue_wr) begin
          dst_d = dst_q + STEP;
          out_d = out_q - 1'b1;
        end else if (issue_rd) begin
          src_d  = src_q + STEP;
          rcnt_d = rcnt_q - 1'b1;
          out_d  = out_q + 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request register load: write-back has priority over new reads.
  always_comb begin
    wraddr_d = wraddr_q;
    wrdata_d = wrdata_q;
    wrvld_d  = wrvld_q;
    is_wr_d  = is_wr_q;
    if (load_ok) begin
      wrvld_d = issue_wr || issue_rd;
      if (issue_wr) begin
        wraddr_d = dst_q;
        wrdata_d = {`POWLIB_OP_WRITE, {B_BEW{1'b1}}, fifo_mem[rptr_q]};
        is_wr_d  = 1'b1;
      end else if (issue_rd) begin
        wraddr_d = src_q;
        wrdata_d = {`POWLIB_OP_READ, {B_BEW{1'b1}}, B_DW'(RET_ADDR)};
        is_wr_d  = 1'b0;
      end
    end
  end

  // Control and request state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      src_q    <= '0;
      dst_q    <= '0;
      rcnt_q   <= '0;
      wcnt_q   <= '0;
      out_q    <= '0;
      wraddr_q <= '0;
      wrdata_q <= '0;
      wrvld_q  <= 1'b0;
      is_wr_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      rcnt_q   <= rcnt_d;
      wcnt_q   <= wcnt_d;
      out_q    <= out_d;
      wraddr_q <= wraddr_d;
      wrdata_q <= wrdata_d;
      wrvld_q  <= wrvld_d;
      is_wr_q  <= is_wr_d;
    end
  end

  // Response FIFO; simultaneous push and pop leave occupancy unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr_q <= '0;
      wptr_q <= '0;
      fcnt_q <= '0;
      for (int i = 0; i < int'(MAXOUT); i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wptr_q] <= rddata[B_DW-1:0];
        wptr_q           <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   fcnt_q <= fcnt_q + 1'b1;
        2'b01:   fcnt_q <= fcnt_q - 1'b1;
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_powlib_ipcopy.sv
// Bench for powlib_ipcopy: a RAM model answers read requests, copies are
// predicted from a snapshot of source memory taken at start.

`ifndef POWLIB_BW
`define POWLIB_BW 8
`endif
`ifndef POWLIB_OPW
`define POWLIB_OPW 4
`endif
`ifndef POWLIB_OP_WRITE
`define POWLIB_OP_WRITE 4'd0
`endif
`ifndef POWLIB_OP_READ
`define POWLIB_OP_READ 4'd1
`endif

module tb_powlib_ipcopy;
  localparam logic [15:0] RET  = 16'hFFF0;
  localparam logic [3:0]  OPRD = `POWLIB_OP_READ;
  localparam logic [3:0]  OPWR = `POWLIB_OP_WRITE;

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [15:0] src = '0, dst = '0, len = '0;
  logic        busy, done, wrvld, rdrdy;
  logic [15:0] wraddr;
  logic [21:0] wrdata;
  logic        wrrdy = 1'b1, rdvld = 1'b0;
  logic [15:0] rdaddr = '0;
  logic [21:0] rddata = '0;

  always #5 clk = ~clk;

  powlib_ipcopy dut (
    .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .wraddr(wraddr), .wrdata(wrdata), .wrvld(wrvld),
    .wrrdy(wrrdy), .rdaddr(rdaddr), .rddata(rddata), .rdvld(rdvld), .rdrdy(rdrdy)
  );

  int checks = 0, failures = 0;
  logic [15:0] mem [0:65535];
  logic [15:0] resp_q[$];
  logic [15:0] rd_seen[$], wa_seen[$], wd_seen[$];
  int done_cnt, busy_cnt, vld_cnt, cycnum = 0, first_vld, first_busy, first_done;
  int rd_acc, wr_acc, start_idx;
  logic prev_stall = 1'b0;
  logic [15:0] prev_addr;
  logic [21:0] prev_data;
  bit rdy_rand = 0, stray_en = 0, resp_en = 1;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    rd_seen.delete(); wa_seen.delete(); wd_seen.delete();
    done_cnt = 0; busy_cnt = 0; vld_cnt = 0; rd_acc = 0; wr_acc = 0;
    first_vld = -1; first_busy = -1; first_done = -1; prev_stall = 1'b0;
  endtask

  // One clock: observe at negedge (RAM model acts on accepted packets), drive after posedge.
  task automatic cyc();
    @(negedge clk);
    cycnum++;
    chk("rdrdy_high", rdrdy, 1);
    if (busy) begin busy_cnt++; if (first_busy < 0) first_busy = cycnum; end
    if (done) begin
      done_cnt++;
      if (first_done < 0) first_done = cycnum;
      chk("busy_low_at_done", busy, 0);
    end
    if (wrvld) begin vld_cnt++; if (first_vld < 0) first_vld = cycnum; end
    if (prev_stall) begin
      chk("hold_vld", wrvld, 1);
      chk("hold_addr", wraddr, prev_addr);
      chk("hold_data", wrdata, prev_data);
    end
    prev_stall = wrvld && !wrrdy;
    prev_addr  = wraddr;
    prev_data  = wrdata;
    if (wrvld && wrrdy) begin
      if (wrdata[21:18] == OPRD) begin
        chk("rd_pkt_be_data", wrdata[17:0], {2'b11, RET});
        rd_seen.push_back(wraddr);
        resp_q.push_back(mem[wraddr]);
        rd_acc++;
      end else begin
        chk("wr_op", wrdata[21:18], OPWR);
        chk("wr_be", wrdata[17:16], 2'b11);
        wa_seen.push_back(wraddr);
        wd_seen.push_back(wrdata[15:0]);
        mem[wraddr] = wrdata[15:0];
        wr_acc++;
      end
      chk("outstanding_le4", (rd_acc - wr_acc <= 4) ? 1 : 0, 1);
    end
    @(posedge clk);
    #1;
    rdvld = 1'b0;
    if (resp_en && resp_q.size() > 0 && $urandom_range(0, 2) != 0) begin
      rdvld  = 1'b1;
      rdaddr = RET;
      rddata = {OPWR, 2'b11, resp_q.pop_front()};
    end else if (stray_en && $urandom_range(0, 3) == 0) begin
      rdvld  = 1'b1;
      rdaddr = 16'h1234;
      rddata = {OPWR, 2'b11, 16'($urandom)};
    end
    wrrdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic run_copy(string tag, logic [15:0] s, logic [15:0] d, logic [15:0] l,
                          bit rnd, bit stray, bit bogus);
    logic [15:0] exp_d[$];
    int budget;
    for (int k = 0; k < int'(l); k++) exp_d.push_back(mem[16'(s + 2*k)]);
    clear_obs();
    rdy_rand = rnd;
    stray_en = stray;
    src = s; dst = d; len = l; start = 1'b1;
    start_idx = cycnum + 1;
    cyc();
    start = 1'b0;
    budget = 0;
    while (done_cnt == 0 && budget < 2000) begin
      if (bogus && budget == 4) begin
        chk({tag, "_busy_at_restart"}, busy, 1);
        start = 1'b1; len = 16'd3; src = 16'h2000; dst = 16'hC000;
      end else begin
        start = 1'b0;
      end
      cyc();
      budget++;
    end
    start = 1'b0;
    chk({tag, "_no_timeout"}, (budget < 2000) ? 1 : 0, 1);
    repeat (3) cyc();
    stray_en = 0;
    rdy_rand = 0;
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_rd_count"}, rd_seen.size(), l);
    chk({tag, "_wr_count"}, wa_seen.size(), l);
    if (l == 0) begin
      chk({tag, "_done_latency"}, first_done, start_idx + 1);
      chk({tag, "_busy_cycles"}, busy_cnt, 0);
      chk({tag, "_vld_cycles"}, vld_cnt, 0);
    end else if (!rnd) begin
      chk({tag, "_busy_latency"}, first_busy, start_idx + 1);
      chk({tag, "_vld_latency"}, first_vld, start_idx + 2);
    end
    for (int k = 0; k < int'(l); k++) begin
      chk({tag, "_rd_addr"}, (k < rd_seen.size()) ? rd_seen[k] : 16'hxxxx, 16'(s + 2*k));
      chk({tag, "_wr_addr"}, (k < wa_seen.size()) ? wa_seen[k] : 16'hxxxx, 16'(d + 2*k));
      chk({tag, "_wr_data"}, (k < wd_seen.size()) ? wd_seen[k] : 16'hxxxx, exp_d[k]);
      chk({tag, "_ram"}, mem[16'(d + 2*k)], exp_d[k]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    logic [15:0] s, d, l;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[16'h5556] = 16'h1234;

    // Reset values.
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wrvld", wrvld, 0);
    chk("rst_rdrdy", rdrdy, 1);
    chk("rst_wraddr", wraddr, 0);
    chk("rst_wrdata", wrdata, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) cyc();

    run_copy("single", 16'h5556, 16'h6000, 16'd1, 0, 0, 0);
    chk("single_ram_6000", mem[16'h6000], 16'h1234);

    run_copy("burst", 16'h5556, 16'h7000, 16'd8, 1, 0, 0);
    run_copy("zero", 16'h1000, 16'h8000, 16'd0, 0, 0, 0);
    run_copy("wrap", 16'hFFFE, 16'h8100, 16'd2, 0, 0, 0);
    run_copy("stray", 16'h3000, 16'hA000, 16'd6, 1, 1, 1);

    // Reset in the middle of a copy.
    clear_obs();
    src = 16'h0100; dst = 16'h9000; len = 16'd8; start = 1'b1;
    cyc();
    start = 1'b0;
    budget = 0;
    while (wr_acc < 3 && budget < 500) begin cyc(); budget++; end
    chk("midrst_reached", (budget < 500) ? 1 : 0, 1);
    rst = 1'b0;
    resp_en = 0;
    rdvld = 1'b0;
    #1;
    chk("midrst_wrvld", wrvld, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    repeat (2) cyc();
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear_obs();
    resp_en = 1;
    resp_q.push_back(16'hDEAD);
    resp_q.push_back(16'hBEEF);
    budget = 0;
    while (resp_q.size() > 0 && budget < 100) begin cyc(); budget++; end
    repeat (3) cyc();
    chk("late_resp_drained", resp_q.size(), 0);
    chk("late_resp_no_vld", vld_cnt, 0);
    chk("late_resp_no_busy", busy_cnt, 0);
    chk("late_resp_no_done", done_cnt, 0);
    run_copy("after_rst", 16'h0100, 16'h9800, 16'd8, 0, 0, 0);

    // Randomized copies over disjoint source/destination regions.
    for (int t = 0; t < 4; t++) begin
      s = {2'b00, 13'($urandom), 1'b0};
      d = {2'b10, 13'($urandom), 1'b0};
      l = 16'($urandom_range(1, 12));
      run_copy("random", s, d, l, 1, t[0], 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
